// File: rtl/bpred_pkg.sv
// Shared types and constants for the next-PC predictor: counter encoding, default geometry, BTB entry layout.
// No logic; latency and backpressure are properties of the modules that import it.
package bpred_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam int          DEF_XLEN     = 32;
    localparam int          DEF_ENTRIES  = 16;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          PC_INC       = 4;

    localparam int DEF_IDXW = $clog2(DEF_ENTRIES);
    localparam int DEF_TAGW = DEF_XLEN - DEF_IDXW - 2;

    // Entry layout at the default geometry; the top re-declares it at its own parameter widths.
    typedef struct packed {
        logic                valid;
        logic [DEF_TAGW-1:0] tag;
        logic [DEF_XLEN-1:0] target;
        ctr_e                ctr;
    } btb_entry_t;

endpackage

// File: rtl/bpred_counter2.sv
// 2-bit saturating direction counter next-state function.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of state and outcome.
module bpred_counter2
    import bpred_pkg::*;
(
    input  ctr_e state,
    input  logic taken,
    output ctr_e next_state
);

    always_comb begin
        next_state = state;
        unique case (state)
            SNT: next_state = taken ? WNT : SNT;
            WNT: next_state = taken ? WT  : SNT;
            WT:  next_state = taken ? ST  : WNT;
            ST:  next_state = taken ? ST  : WT;
            default: next_state = state;
        endcase
    end

endmodule

// File: rtl/bpred_next_pc.sv
// Next-PC generator: direct-mapped BTB + 2-bit counters feeding the fetch PC register. Optional BPRED_STATS_EN adds counters.
// Latency: prediction is combinational from pc_i; table updates become visible the cycle after upd_valid_i.
// Backpressure: stall_i drops pc_en_o unless redirect_i overrides; training is never stalled.
module bpred_next_pc
    import bpred_pkg::*;
#(
    parameter int               XLEN     = DEF_XLEN,
    parameter int               ENTRIES  = DEF_ENTRIES,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic            i_clk,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
`ifdef BPRED_STATS_EN
    output logic [31:0]     stat_branches_o,
    output logic [31:0]     stat_mispred_o,
`endif
    output logic [XLEN-1:0] next_pc_o,
    output logic            pc_en_o,
    output logic            pred_taken_o
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;
    localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

    typedef struct packed {
        logic            valid;
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] target;
        ctr_e            ctr;
    } entry_t;

    entry_t tbl [ENTRIES];

    logic [IDXW-1:0] rd_idx, wr_idx;
    logic [TAGW-1:0] rd_tag, wr_tag;
    entry_t          rd_ent, wr_ent;
    logic            rd_hit, wr_hit;
    ctr_e            ctr_nxt;
    logic            unused_lsbs;

    assign rd_idx      = pc_i[IDXW+1:2];
    assign rd_tag      = pc_i[XLEN-1:IDXW+2];
    assign wr_idx      = upd_pc_i[IDXW+1:2];
    assign wr_tag      = upd_pc_i[XLEN-1:IDXW+2];
    assign unused_lsbs = ^{pc_i[1:0], upd_pc_i[1:0]};

    assign rd_ent = tbl[rd_idx];
    assign wr_ent = tbl[wr_idx];
    assign rd_hit = rd_ent.valid && (rd_ent.tag == rd_tag);
    assign wr_hit = wr_ent.valid && (wr_ent.tag == wr_tag);

    bpred_counter2 u_ctr (
        .state      (wr_ent.ctr),
        .taken      (upd_taken_i),
        .next_state (ctr_nxt)
    );

    // Table may still hold stale state before the first reset edge, so gate the prediction.
    always_comb begin
        pred_taken_o = !rst_i && rd_hit && rd_ent.ctr[1];
        pc_en_o      = rst_i || redirect_i || !stall_i;
        if (rst_i)
            next_pc_o = RESET_PC;
        else if (redirect_i)
            next_pc_o = redirect_pc_i;
        else if (pred_taken_o)
            next_pc_o = rd_ent.target;
        else
            next_pc_o = pc_i + INC;
    end

    always_ff @(posedge i_clk) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++)
                tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
        end else if (upd_valid_i) begin
            if (wr_hit) begin
                tbl[wr_idx].ctr <= ctr_nxt;
                if (upd_taken_i)
                    tbl[wr_idx].target <= upd_target_i;
            end else if (upd_taken_i) begin
                tbl[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: upd_target_i, ctr: WT};
            end
        end
    end

`ifdef BPRED_STATS_EN
    always_ff @(posedge i_clk) begin
        if (rst_i) begin
            stat_branches_o <= '0;
            stat_mispred_o  <= '0;
        end else begin
            if (upd_valid_i && stat_branches_o != '1)
                stat_branches_o <= stat_branches_o + 32'd1;
            if (redirect_i && stat_mispred_o != '1)
                stat_mispred_o <= stat_mispred_o + 32'd1;
        end
    end
`endif

endmodule
